// File: rtl/cpu_step_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_step_pkg
//  Purpose  : Shared types and constants for the CPU step sequencer:
//             FSM state encoding, scan phase encoding and the index of each
//             result register on the result-select mux.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_step_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        ADV  = 3'd2,
        SCAN = 3'd3,
        HALT = 3'd4
    } state_t;

    // Each scanned register takes two cycles: mux settle, then capture.
    localparam logic SCAN_SETTLE = 1'b0;
    localparam logic SCAN_CAPT   = 1'b1;

    // Result register positions on the ressel mux.
    localparam int REG_PC   = 0;
    localparam int REG_A    = 1;
    localparam int REG_B    = 2;
    localparam int REG_FLAG = 3;

endpackage
`default_nettype wire

// File: rtl/cpu_step_sequencer_rise_detect.sv
`default_nettype none
// ============================================================================
//  Module   : rise_detect
//  Purpose  : Registered rising-edge detector. o_rise is high for one cycle,
//             one clock after i_din is first sampled high.
//  Ports    : clock, reset_N (sync, active-low), i_din, o_rise
//  Params   : PREV_RST - reset value of the history flop; 1 suppresses a
//             false edge when the input is already high coming out of reset.
//  Revision : 1.0  initial release
// ============================================================================
module rise_detect #(
    parameter logic PREV_RST = 1'b0
) (
    input  logic clock,
    input  logic reset_N,
    input  logic i_din,
    output logic o_rise
);

    logic r_prev;
    logic r_rise;

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            r_prev <= PREV_RST;
            r_rise <= 1'b0;
        end else begin
            r_prev <= i_din;
            r_rise <= i_din & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/cpu_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_step_sequencer
//  Purpose  : Sequences CPU execution in free-run or single-step mode. Each
//             advance is a one-cycle cpu_adv pulse followed by a scan of all
//             NREG result registers through the ressel mux into snap.
//             endseq freezes the CPU until reset.
//  Ports    : clock, reset_N (sync, active-low), run_sw, step_btn, endseq,
//             resdt_h/resdt_l (mux data) -> cpu_adv, ressel, snap, snap_vld,
//             busy, halted
//  Options  : BREAKPOINT_EN - adds bp_en/bp_addr/bp_hit; a run-mode scan
//             whose PC low byte equals bp_addr drops to IDLE and sets bp_hit.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_step_sequencer
    import cpu_step_pkg::*;
#(
    parameter int RUN_DIV = 25_000_000,
    parameter int NREG    = 4,
    parameter int SEL_W   = 2
) (
    input  logic                 clock,
    input  logic                 reset_N,
    input  logic                 run_sw,
    input  logic                 step_btn,
    input  logic                 endseq,
`ifdef BREAKPOINT_EN
    input  logic                 bp_en,
    input  logic [7:0]           bp_addr,
    output logic                 bp_hit,
`endif
    input  logic [7:0]           resdt_h,
    input  logic [7:0]           resdt_l,
    output logic                 cpu_adv,
    output logic [SEL_W-1:0]     ressel,
    output logic [16*NREG-1:0]   snap,
    output logic                 snap_vld,
    output logic                 busy,
    output logic                 halted
);

    localparam int               DIV_W      = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(RUN_DIV - 1);
    localparam logic [SEL_W-1:0] C_SEL_LAST = SEL_W'(NREG - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [DIV_W-1:0]   r_div;
    logic [SEL_W-1:0]   r_ressel;
    logic               r_phase;
    logic [15:0]        r_snap [NREG];
    logic               w_step_rise;
    logic               w_scan_end;
    logic               w_bp_stop;

    // History flop resets high so a button held through reset is not a step.
    rise_detect #(
        .PREV_RST (1'b1)
    ) u_step_rise (
        .clock   (clock),
        .reset_N (reset_N),
        .i_din   (step_btn),
        .o_rise  (w_step_rise)
    );

    // Capture cycle of the last register: the scan ends on this edge.
    assign w_scan_end = (r_state == SCAN) && (r_phase == SCAN_CAPT) &&
                        (r_ressel == C_SEL_LAST);

`ifdef BREAKPOINT_EN
    assign w_bp_stop = bp_en && (r_snap[REG_PC][7:0] == bp_addr);
`else
    assign w_bp_stop = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cpu_adv      = 1'b0;
        snap_vld     = 1'b0;
        case (r_state)
            IDLE: begin
                if (endseq)           w_state_next = HALT;
                else if (run_sw)      w_state_next = RUN;
                else if (w_step_rise) w_state_next = ADV;
            end
            RUN: begin
                if (endseq)                   w_state_next = HALT;
                else if (!run_sw)             w_state_next = IDLE;
                else if (r_div == C_DIV_LAST) w_state_next = ADV;
            end
            ADV: begin
                cpu_adv      = 1'b1;
                w_state_next = SCAN;
            end
            SCAN: begin
                if (w_scan_end) begin
                    snap_vld = 1'b1;
                    if (endseq)                     w_state_next = HALT;
                    else if (run_sw && !w_bp_stop)  w_state_next = RUN;
                    else                            w_state_next = IDLE;
                end
            end
            HALT:    w_state_next = HALT;
            default: w_state_next = IDLE;
        endcase
    end

    // Divider only counts while staying in RUN, so every entry starts at 0.
    always_ff @(posedge clock) begin
        if (!reset_N) begin
            r_div    <= '0;
            r_ressel <= '0;
            r_phase  <= SCAN_SETTLE;
            for (int i = 0; i < NREG; i++) begin
                r_snap[i] <= 16'h0000;
            end
        end else begin
            r_div <= ((r_state == RUN) && (w_state_next == RUN)) ? r_div + 1'b1 : '0;
            if (r_state == SCAN) begin
                if (r_phase == SCAN_SETTLE) begin
                    r_phase <= SCAN_CAPT;
                end else begin
                    r_phase <= SCAN_SETTLE;
                    for (int i = 0; i < NREG; i++) begin
                        if (r_ressel == SEL_W'(i)) begin
                            r_snap[i] <= {resdt_h, resdt_l};
                        end
                    end
                    r_ressel <= w_scan_end ? '0 : r_ressel + 1'b1;
                end
            end else begin
                r_phase  <= SCAN_SETTLE;
                r_ressel <= '0;
            end
        end
    end

`ifdef BREAKPOINT_EN
    logic r_bp_hit;

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            r_bp_hit <= 1'b0;
        end else if (r_state == ADV) begin
            r_bp_hit <= 1'b0;
        end else if (w_scan_end && !endseq && run_sw && w_bp_stop) begin
            r_bp_hit <= 1'b1;
        end
    end

    assign bp_hit = r_bp_hit;
`endif

    assign ressel = r_ressel;
    assign busy   = (r_state == ADV) || (r_state == SCAN);
    assign halted = (r_state == HALT);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_snap
            assign snap[16*gi +: 16] = r_snap[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_step_sequencer
//  Purpose  : Self-checking bench for cpu_step_sequencer (RUN_DIV=4, NREG=4).
//             The result mux returns {ressel, 8'hA0+ressel}.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_step_sequencer;

    localparam int RUN_DIV  = 4;
    localparam int NREG     = 4;
    localparam int SEL_W    = 2;
    localparam int SCAN_LEN = 2 * NREG;
    localparam int PERIOD   = RUN_DIV + 1 + SCAN_LEN;

    logic                clk = 1'b0;
    logic                reset_N = 1'b0;
    logic                run_sw = 1'b0;
    logic                step_btn = 1'b0;
    logic                endseq = 1'b0;
    logic [7:0]          resdt_h;
    logic [7:0]          resdt_l;
    logic                cpu_adv;
    logic [SEL_W-1:0]    ressel;
    logic [16*NREG-1:0]  snap;
    logic                snap_vld;
    logic                busy;
    logic                halted;
`ifdef BREAKPOINT_EN
    logic                bp_en = 1'b0;
    logic [7:0]          bp_addr = 8'h00;
    logic                bp_hit;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Result mux model: reg i reads {i, 8'hA0 + i}.
    assign resdt_h = {{(8-SEL_W){1'b0}}, ressel};
    assign resdt_l = 8'hA0 + {{(8-SEL_W){1'b0}}, ressel};

    cpu_step_sequencer #(
        .RUN_DIV (RUN_DIV),
        .NREG    (NREG),
        .SEL_W   (SEL_W)
    ) dut (
        .clock    (clk),
        .reset_N  (reset_N),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .endseq   (endseq),
`ifdef BREAKPOINT_EN
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .bp_hit   (bp_hit),
`endif
        .resdt_h  (resdt_h),
        .resdt_l  (resdt_l),
        .cpu_adv  (cpu_adv),
        .ressel   (ressel),
        .snap     (snap),
        .snap_vld (snap_vld),
        .busy     (busy),
        .halted   (halted)
    );

    function automatic logic [16*NREG-1:0] full_snap();
        logic [16*NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) v[16*i +: 16] = 16'(i * 256 + 160 + i);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_step();
        step_btn = 1'b1;
        tick();
        step_btn = 1'b0;
    endtask

    // ---------------- reference model (activity timeline) ----------------
    // mode: 0 idle, 1 running, 2 advancing (pos 0 = adv pulse, 1..SCAN_LEN scan), 3 halted
    int m_mode, m_pos, m_cnt;
    bit m_prev, m_rise, m_scanned;

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_cnt = 0;
        m_prev = 1'b1; m_rise = 1'b0; m_scanned = 1'b0;
    endtask

    task automatic model_edge(input bit run, input bit step, input bit es);
        bit fire;
        fire   = m_rise;
        m_rise = step & ~m_prev;
        m_prev = step;
        case (m_mode)
            0: begin
                if (es) m_mode = 3;
                else if (run) begin m_mode = 1; m_cnt = 0; end
                else if (fire) begin m_mode = 2; m_pos = 0; end
            end
            1: begin
                if (es) m_mode = 3;
                else if (!run) m_mode = 0;
                else if (m_cnt == RUN_DIV - 1) begin m_mode = 2; m_pos = 0; end
                else m_cnt++;
            end
            2: begin
                if (m_pos == SCAN_LEN) begin
                    m_scanned = 1'b1;
                    m_cnt = 0;
                    m_mode = es ? 3 : (run ? 1 : 0);
                end else begin
                    m_pos++;
                end
            end
            default: m_mode = 3;
        endcase
    endtask

    // ---------------------------- tests ----------------------------------
    task automatic test_reset();
        int pulses;
        reset_N = 1'b0; step_btn = 1'b1; run_sw = 1'b0; endseq = 1'b0;
        repeat (3) tick();
        n_tests++; if (cpu_adv !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_adv got=%b exp=0", cpu_adv); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
        n_tests++; if (snap_vld !== 1'b0) begin n_fail++; $display("FAIL reset_snap_vld got=%b exp=0", snap_vld); end
        n_tests++; if (ressel !== '0) begin n_fail++; $display("FAIL reset_ressel got=%0d exp=0", ressel); end
        n_tests++; if (snap !== '0) begin n_fail++; $display("FAIL reset_snap got=%h exp=0", snap); end
        reset_N = 1'b1;
        pulses = 0;
        repeat (5) begin tick(); pulses += int'(cpu_adv); end
        step_btn = 1'b0;
        repeat (10) begin tick(); pulses += int'(cpu_adv); end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL held_step_no_adv got=%0d exp=0", pulses); end
        n_tests++; if (snap !== '0) begin n_fail++; $display("FAIL held_step_snap got=%h exp=0", snap); end
    endtask

    task automatic test_step_single();
        int vld_at;
        bit sel_bad;
        press_step();
        n_tests++; if (cpu_adv !== 1'b0) begin n_fail++; $display("FAIL step_early got=%b exp=0", cpu_adv); end
        tick();
        n_tests++; if (cpu_adv !== 1'b1) begin n_fail++; $display("FAIL step_latency got=%b exp=1", cpu_adv); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL step_busy got=%b exp=1", busy); end
        vld_at = -1; sel_bad = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (snap_vld === 1'b1 && vld_at < 0) vld_at = k;
            if (k <= SCAN_LEN && ressel !== SEL_W'((k - 1) / 2)) sel_bad = 1'b1;
        end
        n_tests++; if (vld_at != SCAN_LEN) begin n_fail++; $display("FAIL step_snap_vld_delay got=%0d exp=%0d", vld_at, SCAN_LEN); end
        n_tests++; if (sel_bad) begin n_fail++; $display("FAIL step_ressel_walk got=bad exp=0,0,1,1,2,2,3,3"); end
        n_tests++; if (snap[31:16] !== 16'h01A1) begin n_fail++; $display("FAIL step_snap1 got=%h exp=01a1", snap[31:16]); end
        n_tests++; if (snap !== full_snap()) begin n_fail++; $display("FAIL step_snap_all got=%h exp=%h", snap, full_snap()); end
        n_tests++; if (busy !== 1'b0 || ressel !== '0) begin n_fail++; $display("FAIL step_back_idle busy=%b ressel=%0d exp=0,0", busy, ressel); end
    endtask

    task automatic test_run_mode();
        int adv_t[$];
        int extra;
        bit bad;
        run_sw = 1'b1;
        for (int t = 0; t < 100; t++) begin
            step_btn = ((t % 7) == 3) && (t < 90);
            tick();
            if (cpu_adv === 1'b1) adv_t.push_back(t);
        end
        step_btn = 1'b0;
        n_tests++; if (adv_t.size() != 8) begin n_fail++; $display("FAIL run_pulse_count got=%0d exp=8", adv_t.size()); end
        bad = 1'b0;
        foreach (adv_t[j]) if (adv_t[j] != RUN_DIV + PERIOD * j) bad = 1'b1;
        n_tests++; if (bad) begin n_fail++; $display("FAIL run_period got_first=%0d exp_first=%0d exp_period=%0d", (adv_t.size() > 0) ? adv_t[0] : -1, RUN_DIV, PERIOD); end
        run_sw = 1'b0;
        extra = 0;
        repeat (20) begin tick(); extra += int'(cpu_adv); end
        n_tests++; if (extra != 0 || busy !== 1'b0) begin n_fail++; $display("FAIL run_stop extra=%0d busy=%b exp=0,0", extra, busy); end
    endtask

    task automatic test_endseq_halt();
        int vld_at, adv_cnt;
        bit hold_bad;
        press_step();
        tick();
        n_tests++; if (cpu_adv !== 1'b1) begin n_fail++; $display("FAIL halt_adv got=%b exp=1", cpu_adv); end
        tick(); tick();
        endseq = 1'b1;
        vld_at = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (snap_vld === 1'b1 && vld_at < 0) vld_at = k;
        end
        n_tests++; if (vld_at != SCAN_LEN - 2) begin n_fail++; $display("FAIL halt_scan_finish got=%0d exp=%0d", vld_at, SCAN_LEN - 2); end
        n_tests++; if (halted !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL halt_state halted=%b busy=%b exp=1,0", halted, busy); end
        run_sw = 1'b1; adv_cnt = 0; hold_bad = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step_btn = $urandom_range(0, 1);
            tick();
            adv_cnt += int'(cpu_adv);
            if (halted !== 1'b1 || snap !== full_snap()) hold_bad = 1'b1;
        end
        n_tests++; if (adv_cnt != 0) begin n_fail++; $display("FAIL halt_no_adv got=%0d exp=0", adv_cnt); end
        n_tests++; if (hold_bad) begin n_fail++; $display("FAIL halt_hold halted=%b snap=%h exp=1,%h", halted, snap, full_snap()); end
        reset_N = 1'b0; endseq = 1'b0; run_sw = 1'b0; step_btn = 1'b0;
        tick();
        reset_N = 1'b1;
        tick();
        n_tests++; if (halted !== 1'b0 || busy !== 1'b0 || snap !== '0) begin n_fail++; $display("FAIL halt_reset halted=%b busy=%b snap=%h exp=0,0,0", halted, busy, snap); end
    endtask

    task automatic test_run_drop_mid_scan();
        int waited, vld_at, extra;
        run_sw = 1'b1;
        waited = 0;
        do begin tick(); waited++; end while (cpu_adv !== 1'b1 && waited < 40);
        n_tests++; if (cpu_adv !== 1'b1) begin n_fail++; $display("FAIL drop_first_adv got=timeout exp=pulse"); end
        tick(); tick(); tick();
        run_sw = 1'b0;
        vld_at = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (snap_vld === 1'b1 && vld_at < 0) vld_at = k;
        end
        n_tests++; if (vld_at != SCAN_LEN - 3) begin n_fail++; $display("FAIL drop_scan_complete got=%0d exp=%0d", vld_at, SCAN_LEN - 3); end
        n_tests++; if (snap !== full_snap() || busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle snap=%h busy=%b", snap, busy); end
        extra = 0;
        repeat (30) begin tick(); extra += int'(cpu_adv); end
        n_tests++; if (extra != 0) begin n_fail++; $display("FAIL drop_no_adv got=%0d exp=0", extra); end
        press_step();
        tick();
        n_tests++; if (cpu_adv !== 1'b1) begin n_fail++; $display("FAIL drop_step_adv got=%b exp=1", cpu_adv); end
        repeat (12) tick();
    endtask

    task automatic test_random_model();
        int shown;
        logic [16*NREG-1:0] exp_snap;
        reset_N = 1'b0; run_sw = 1'b0; step_btn = 1'b0; endseq = 1'b0;
        tick(); tick();
        model_reset();
        reset_N = 1'b1;
        shown = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 29) == 0) run_sw = ~run_sw;
            step_btn = ($urandom_range(0, 5) == 0);
            endseq   = (c >= 380);
            tick();
            model_edge(run_sw, step_btn, endseq);
            exp_snap = m_scanned ? full_snap() : '0;
            n_tests++;
            if (cpu_adv !== (m_mode == 2 && m_pos == 0) ||
                snap_vld !== (m_mode == 2 && m_pos == SCAN_LEN) ||
                busy !== (m_mode == 2) || halted !== (m_mode == 3) ||
                (m_mode != 2 && snap !== exp_snap)) begin
                n_fail++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle%0d got adv=%b vld=%b busy=%b halt=%b exp adv=%b vld=%b busy=%b halt=%b",
                             c, cpu_adv, snap_vld, busy, halted,
                             (m_mode == 2 && m_pos == 0), (m_mode == 2 && m_pos == SCAN_LEN),
                             (m_mode == 2), (m_mode == 3));
                end
            end
        end
        reset_N = 1'b0; endseq = 1'b0; run_sw = 1'b0; step_btn = 1'b0;
        tick();
        reset_N = 1'b1;
        tick();
    endtask

`ifdef BREAKPOINT_EN
    task automatic test_breakpoint();
        int waited;
        bp_en = 1'b1; bp_addr = 8'hA0; run_sw = 1'b1;
        waited = 0;
        do begin tick(); waited++; end while (snap_vld !== 1'b1 && waited < 40);
        tick();
        n_tests++; if (busy !== 1'b0 || bp_hit !== 1'b1) begin n_fail++; $display("FAIL bp_stop busy=%b bp_hit=%b exp=0,1", busy, bp_hit); end
        run_sw = 1'b0;
        repeat (3) tick();
        n_tests++; if (busy !== 1'b0 || bp_hit !== 1'b1) begin n_fail++; $display("FAIL bp_hold busy=%b bp_hit=%b exp=0,1", busy, bp_hit); end
        press_step();
        tick();
        tick();
        n_tests++; if (bp_hit !== 1'b0) begin n_fail++; $display("FAIL bp_clear got=%b exp=0", bp_hit); end
        bp_en = 1'b0;
        repeat (12) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_step_single();
        test_run_mode();
        test_endseq_halt();
        test_run_drop_mid_scan();
        test_random_model();
`ifdef BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
